// File: rtl/dcache_ctrl.sv
`timescale 1ns/1ps
// Direct-mapped, write-through, no-write-allocate data cache controller with one word per line.
// Load hits complete in the same cycle; misses and all stores stall the pipeline until the backing memory acks.
module dcache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = DATA_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [SETS-1:0]         valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q  [SETS];
  logic [TAG_W-1:0]        tag_d  [SETS];
  logic [DATA_WIDTH-1:0]   data_q [SETS];
  logic [DATA_WIDTH-1:0]   data_d [SETS];
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [IDX_W-1:0]        lat_idx;
  logic [TAG_W-1:0]        lat_tag;
  logic [DATA_WIDTH-1:0]   word_addr;
  logic                    hit;
  logic                    unused_addr_bits;

  assign idx              = addr_i[2 +: IDX_W];
  assign tag              = addr_i[DATA_WIDTH-1 -: TAG_W];
  assign lat_idx          = addr_q[2 +: IDX_W];
  assign lat_tag          = addr_q[DATA_WIDTH-1 -: TAG_W];
  assign word_addr        = {addr_i[DATA_WIDTH-1:2], 2'b00};
  assign hit              = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr_bits = ^addr_i[1:0];

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    rdata_o     = '0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          rdata_o = data_q[idx];
        end
        // done_q marks the first cycle after an ack: the frozen access is
        // released here and must neither be counted as a hit nor re-issued.
        if (req_i) begin
          if (!we_i) begin
            if (hit) begin
              if (!done_q && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + 1'b1;
              end
            end else begin
              stall_o = 1'b1;
              state_d = FILL;
              addr_d  = word_addr;
              if (miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
              end
            end
          end else if (!done_q) begin
            stall_o = 1'b1;
            state_d = WRITE;
            addr_d  = word_addr;
            wdata_d = wdata_i;
            if (hit) begin
              data_d[idx] = wdata_i;
            end
          end
        end
      end

      FILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        if (mem_ack_i) begin
          valid_d[lat_idx] = 1'b1;
          tag_d[lat_idx]   = lat_tag;
          data_d[lat_idx]  = mem_rdata_i;
          state_d          = IDLE;
          done_d           = 1'b1;
        end
      end

      WRITE: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_ack_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag/data storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
// Directed bench for dcache_ctrl: vector table for single-cycle IDLE decode plus hand sequences for misses, stores, reset and saturation.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [15:0] hit_cnt_o, miss_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  dcache_ctrl #(.DATA_WIDTH(32), .SETS(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic        exp_stall;
    logic        exp_mreq;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = 1'b0;
    mem_ack_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One access held until stall_o drops; the memory acks after n request cycles.
  // addr_i/wdata_i are scrambled while stalled to prove the request was latched.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rv, input int n, output int stalls,
                        output logic [31:0] rd, output int nmem,
                        output logic [31:0] maddr, output logic [31:0] mwdata);
    int reqc;
    bit done;
    stalls = 0; nmem = 0; reqc = 0; rd = '0; maddr = '0; mwdata = '0; done = 0;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!stall_o) begin
        rd = rdata_o;
        done = 1;
      end else begin
        stalls++;
        if (mem_req_o) begin
          if (reqc == n) begin
            mem_ack_i = 1'b1;
            mem_rdata_i = rv;
            nmem++;
            maddr = mem_addr_o;
            mwdata = mem_wdata_o;
          end
          reqc++;
        end
      end
      @(posedge clk); #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        addr_i = a;
        wdata_i = wd;
      end else if (stall_o) begin
        addr_i = a ^ 32'h40;
        wdata_i = ~wd;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL access_timeout: addr 0x%0h still stalled, required completion", a);
    end
    req_i = 1'b0;
  endtask

  int          stalls, nmem;
  logic [31:0] rd, maddr, mwdata;

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_hit_cnt", {16'b0, hit_cnt_o}, 32'h0);
    chk("rst_miss_cnt", {16'b0, miss_cnt_o}, 32'h0);
    @(posedge clk); #1;

    // Cold load miss: 1 IDLE cycle + 4 FILL cycles of stall
    access(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, stalls, rd, nmem, maddr, mwdata);
    chk("cold_stalls", stalls, 32'd5);
    chk("cold_rdata", rd, 32'hDEADBEEF);
    chk("cold_fill_addr", maddr, 32'h100);
    chk("cold_miss_cnt", {16'b0, miss_cnt_o}, 32'd1);
    chk("cold_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);

    access(1'b0, 32'h100, 32'h0, 32'h0, 1, stalls, rd, nmem, maddr, mwdata);
    chk("rehit_stalls", stalls, 32'd0);
    chk("rehit_memreqs", nmem, 32'd0);
    chk("rehit_rdata", rd, 32'hDEADBEEF);
    chk("rehit_hit_cnt", {16'b0, hit_cnt_o}, 32'd1);

    tbl[0] = '{1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h120, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h103, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    // req_i is withdrawn before each edge, so these probe IDLE decode only.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      req_i = tbl[i].req; we_i = tbl[i].we; addr_i = tbl[i].addr; wdata_i = 32'hCAFE0000;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), {31'b0, stall_o}, {31'b0, tbl[i].exp_stall});
      chk($sformatf("vec%0d_mem_req", i), {31'b0, mem_req_o}, {31'b0, tbl[i].exp_mreq});
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata_o, tbl[i].exp_rd);
      #1 req_i = 1'b0;
    end
    @(posedge clk); #1;
    chk("tbl_hit_cnt", {16'b0, hit_cnt_o}, 32'd1);
    chk("tbl_miss_cnt", {16'b0, miss_cnt_o}, 32'd1);

    access(1'b1, 32'h100, 32'h12345678, 32'h0, 1, stalls, rd, nmem, maddr, mwdata);
    chk("st_hit_stalls", stalls, 32'd3);
    chk("st_hit_writes", nmem, 32'd1);
    chk("st_hit_addr", maddr, 32'h100);
    chk("st_hit_data", mwdata, 32'h12345678);
    access(1'b0, 32'h100, 32'h0, 32'h0, 1, stalls, rd, nmem, maddr, mwdata);
    chk("ld_after_st_stalls", stalls, 32'd0);
    chk("ld_after_st_rdata", rd, 32'h12345678);
    chk("ld_after_st_hit_cnt", {16'b0, hit_cnt_o}, 32'd2);

    // Store miss must not allocate
    access(1'b1, 32'h200, 32'hAAAA5555, 32'h0, 2, stalls, rd, nmem, maddr, mwdata);
    chk("st_miss_writes", nmem, 32'd1);
    chk("st_miss_addr", maddr, 32'h200);
    chk("st_miss_data", mwdata, 32'hAAAA5555);
    access(1'b0, 32'h200, 32'h0, 32'hAAAA5555, 1, stalls, rd, nmem, maddr, mwdata);
    chk("ld_200_stalls", stalls, 32'd3);
    chk("ld_200_rdata", rd, 32'hAAAA5555);
    chk("ld_200_miss_cnt", {16'b0, miss_cnt_o}, 32'd2);

    do_reset();
    access(1'b0, 32'h100, 32'h0, 32'h11111111, 1, stalls, rd, nmem, maddr, mwdata);
    access(1'b0, 32'h120, 32'h0, 32'h22222222, 1, stalls, rd, nmem, maddr, mwdata);
    chk("conf_120_rdata", rd, 32'h22222222);
    access(1'b0, 32'h100, 32'h0, 32'h33333333, 1, stalls, rd, nmem, maddr, mwdata);
    chk("conf_100_rdata", rd, 32'h33333333);
    chk("conf_miss_cnt", {16'b0, miss_cnt_o}, 32'd3);
    chk("conf_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);

    // Reset in the middle of a FILL, then a late ack
    do_reset();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100;
    @(negedge clk);
    chk("rf_idle_stall", {31'b0, stall_o}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rf_fill_mem_req", {31'b0, mem_req_o}, 32'h1);
    rst = 1'b1; req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rf_post_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rf_post_miss_cnt", {16'b0, miss_cnt_o}, 32'd0);
    chk("rf_post_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("rf_late_ack_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rf_late_ack_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    access(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, stalls, rd, nmem, maddr, mwdata);
    chk("rf_reload_stalls", stalls, 32'd3);
    chk("rf_reload_rdata", rd, 32'hDEADBEEF);
    chk("rf_reload_miss_cnt", {16'b0, miss_cnt_o}, 32'd1);
    chk("rf_reload_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);

    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100;
    repeat (65540) @(posedge clk);
    #1 req_i = 1'b0;
    @(negedge clk);
    chk("sat_hit_cnt", {16'b0, hit_cnt_o}, 32'h0000FFFF);
    chk("sat_miss_cnt", {16'b0, miss_cnt_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
